// File: rtl/kof_sprite_pkg.sv
// Shared types, default sprite geometry and the frame base helper for the kick sprite path.
package kof_sprite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } seq_state_t;

    localparam int FRAME_W_DEF    = 96;
    localparam int FRAME_H_DEF    = 112;
    localparam int NUM_FRAMES_DEF = 6;

    // Start address of frame f inside the sprite ROM; only ever called with constant
    // arguments, so each result folds into a table entry rather than a multiplier.
    function automatic int frame_base(input int f, input int fw, input int fh);
        return f * fw * fh;
    endfunction

endpackage

// File: rtl/kyo_kick_addr_gen.sv
// Converts the draw coordinate into a registered sprite ROM address and in-box flag,
// using the frame-latched (shadow) sprite position and mirror setting.
module kyo_kick_addr_gen
    import kof_sprite_pkg::*;
#(
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int FRAME_H    = FRAME_H_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF,
    parameter int ADDR_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [9:0]        draw_x_i,
    input  logic [9:0]        draw_y_i,
    input  logic [9:0]        pos_x_i,
    input  logic [9:0]        pos_y_i,
    input  logic              mirror_i,
    input  logic [2:0]        frame_idx_i,
    output logic [ADDR_W-1:0] rom_address_o,
    output logic              sprite_on_o
);

    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [9:0]        col;
    logic              inBox;
    logic [ADDR_W-1:0] frameBase;
    logic [ADDR_W-1:0] rowOffset;
    logic [ADDR_W-1:0] rom_address_d;
    logic              sprite_on_d;
    logic [ADDR_W-1:0] rom_address_q;
    logic              sprite_on_q;

    // Offsets wrap in 10 bits, so pixels left of or above the sprite become large and fall outside.
    always_comb begin
        dx        = draw_x_i - pos_x_i;
        dy        = draw_y_i - pos_y_i;
        inBox     = (dx < 10'(FRAME_W)) && (dy < 10'(FRAME_H));
        col       = mirror_i ? (10'(FRAME_W - 1) - dx) : dx;
        rowOffset = ADDR_W'(dy) * ADDR_W'(FRAME_W);
    end

    // Frame base is a mux over constant entries, never a runtime multiply by the frame index.
    always_comb begin
        frameBase = '0;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            if (frame_idx_i == 3'(f)) begin
                frameBase = ADDR_W'(frame_base(f, FRAME_W, FRAME_H));
            end
        end
    end

    // Outside the box the address is forced to zero so the ROM sees a quiet bus.
    always_comb begin
        rom_address_d = '0;
        sprite_on_d   = 1'b0;
        if (inBox) begin
            rom_address_d = frameBase + rowOffset + ADDR_W'(col);
            sprite_on_d   = 1'b1;
        end
    end

    // One cycle of address latency; the ROM and renderer add the second cycle downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_address_q <= '0;
            sprite_on_q   <= 1'b0;
        end else begin
            rom_address_q <= rom_address_d;
            sprite_on_q   <= sprite_on_d;
        end
    end

    assign rom_address_o = rom_address_q;
    assign sprite_on_o   = sprite_on_q;

endmodule

// File: rtl/kyo_kick_sequencer.sv
// Kick animation sequencer: steps frames on the vsync time base, latches the sprite
// position once per frame, and drives the sprite address generator.
module kyo_kick_sequencer
    import kof_sprite_pkg::*;
#(
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int FRAME_H    = FRAME_H_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF,
    parameter int HOLD_VS    = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              vsync_start,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              mirror,
    input  logic              kick_req,
    output logic              kick_busy,
    output logic              kick_done,
    output logic [2:0]        frame_idx,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on
);

    localparam int HOLD_W = (HOLD_VS > 1) ? $clog2(HOLD_VS) : 1;

    seq_state_t        state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [2:0]        frame_idx_q;
    logic              kick_busy_q;
    logic              kick_done_q;
    logic [9:0]        pos_x_s_q;
    logic [9:0]        pos_y_s_q;
    logic              mirror_s_q;

    // Animation FSM with hold counter, frame index and registered busy/done flags.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            frame_idx_q <= '0;
            kick_busy_q <= 1'b0;
            kick_done_q <= 1'b0;
        end else begin
            kick_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (kick_req) begin
                        kick_busy_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        frame_idx_q <= '0;
                        state_q     <= vsync_start ? ACTIVE : ARMED;
                    end
                end
                ARMED: begin
                    if (vsync_start) begin
                        hold_cnt_q  <= '0;
                        frame_idx_q <= '0;
                        state_q     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (vsync_start) begin
                        if (hold_cnt_q != HOLD_W'(HOLD_VS - 1)) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end else begin
                            hold_cnt_q <= '0;
                            if (frame_idx_q == 3'(NUM_FRAMES - 1)) begin
                                frame_idx_q <= '0;
                                kick_done_q <= 1'b1;
                                kick_busy_q <= 1'b0;
                                state_q     <= IDLE;
                            end else begin
                                frame_idx_q <= frame_idx_q + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    kick_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Position and mirror are sampled only at frame boundaries so one screen never mixes two.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_s_q  <= '0;
            pos_y_s_q  <= '0;
            mirror_s_q <= 1'b0;
        end else if (vsync_start) begin
            pos_x_s_q  <= pos_x;
            pos_y_s_q  <= pos_y;
            mirror_s_q <= mirror;
        end
    end

    kyo_kick_addr_gen #(
        .FRAME_W    (FRAME_W),
        .FRAME_H    (FRAME_H),
        .NUM_FRAMES (NUM_FRAMES),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk_i         (vga_clk),
        .rst_ni        (reset_n),
        .draw_x_i      (draw_x),
        .draw_y_i      (draw_y),
        .pos_x_i       (pos_x_s_q),
        .pos_y_i       (pos_y_s_q),
        .mirror_i      (mirror_s_q),
        .frame_idx_i   (frame_idx_q),
        .rom_address_o (rom_address),
        .sprite_on_o   (sprite_on)
    );

    assign kick_busy = kick_busy_q;
    assign kick_done = kick_done_q;
    assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_kyo_kick_sequencer.sv
// Directed testbench for kyo_kick_sequencer with hand-computed expectations.
module tb_kyo_kick_sequencer;

    logic        vga_clk;
    logic        reset_n;
    logic        vsync_start;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        mirror;
    logic        kick_req;
    logic        kick_busy;
    logic        kick_done;
    logic [2:0]  frame_idx;
    logic [15:0] rom_address;
    logic        sprite_on;

    int checks;
    int errors;

    kyo_kick_sequencer dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .vsync_start (vsync_start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .mirror      (mirror),
        .kick_req    (kick_req),
        .kick_busy   (kick_busy),
        .kick_done   (kick_done),
        .frame_idx   (frame_idx),
        .rom_address (rom_address),
        .sprite_on   (sprite_on)
    );

    // Free-running pixel clock.
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic cycle();
        @(negedge vga_clk);
    endtask

    task automatic pulse_vsync();
        vsync_start = 1'b1;
        cycle();
        vsync_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cycle();
        checks++;
        if ({rom_address, sprite_on, kick_busy, kick_done, frame_idx} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got addr=%0d on=%0b busy=%0b done=%0b frame=%0d required all 0",
                     rom_address, sprite_on, kick_busy, kick_done, frame_idx);
        end
        reset_n = 1'b1;
        repeat (4) cycle();
        checks++;
        if ({rom_address, sprite_on, kick_busy, kick_done, frame_idx} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got addr=%0d on=%0b busy=%0b done=%0b frame=%0d required all 0",
                     rom_address, sprite_on, kick_busy, kick_done, frame_idx);
        end
    endtask

    task automatic test_addr_corners();
        pos_x  = 10'd100;
        pos_y  = 10'd200;
        mirror = 1'b0;
        pulse_vsync();
        draw_x = 10'd100; draw_y = 10'd200;
        cycle();
        checks++;
        if (rom_address !== 16'd0 || sprite_on !== 1'b1) begin
            errors++;
            $display("[TB] FAIL corner_top_left: got addr=%0d on=%0b required addr=0 on=1", rom_address, sprite_on);
        end
        draw_x = 10'd195; draw_y = 10'd311;
        cycle();
        checks++;
        if (rom_address !== 16'd10751 || sprite_on !== 1'b1) begin
            errors++;
            $display("[TB] FAIL corner_bottom_right: got addr=%0d on=%0b required addr=10751 on=1", rom_address, sprite_on);
        end
        draw_x = 10'd99; draw_y = 10'd200;
        cycle();
        checks++;
        if (rom_address !== 16'd0 || sprite_on !== 1'b0) begin
            errors++;
            $display("[TB] FAIL left_of_box: got addr=%0d on=%0b required addr=0 on=0", rom_address, sprite_on);
        end
        draw_x = 10'd196; draw_y = 10'd200;
        cycle();
        checks++;
        if (rom_address !== 16'd0 || sprite_on !== 1'b0) begin
            errors++;
            $display("[TB] FAIL right_of_box: got addr=%0d on=%0b required addr=0 on=0", rom_address, sprite_on);
        end
        draw_x = 10'd100; draw_y = 10'd312;
        cycle();
        checks++;
        if (sprite_on !== 1'b0) begin
            errors++;
            $display("[TB] FAIL below_box: got on=%0b required on=0", sprite_on);
        end
        // Position input moves without vsync: shadows must hold the old position.
        pos_x  = 10'd300;
        draw_x = 10'd101; draw_y = 10'd201;
        cycle();
        checks++;
        if (rom_address !== 16'd97 || sprite_on !== 1'b1) begin
            errors++;
            $display("[TB] FAIL shadow_hold: got addr=%0d on=%0b required addr=97 on=1", rom_address, sprite_on);
        end
        pos_x = 10'd100;
    endtask

    task automatic test_mirror();
        mirror = 1'b1;
        draw_x = 10'd100; draw_y = 10'd200;
        cycle();
        checks++;
        if (rom_address !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mirror_before_vsync: got addr=%0d required 0", rom_address);
        end
        pulse_vsync();
        cycle();
        checks++;
        if (rom_address !== 16'd95 || sprite_on !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mirror_left_edge: got addr=%0d on=%0b required addr=95 on=1", rom_address, sprite_on);
        end
        draw_x = 10'd195; draw_y = 10'd200;
        cycle();
        checks++;
        if (rom_address !== 16'd0 || sprite_on !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mirror_right_edge: got addr=%0d on=%0b required addr=0 on=1", rom_address, sprite_on);
        end
        mirror = 1'b0;
        pulse_vsync();
        draw_x = 10'd1023; draw_y = 10'd1023;
        cycle();
    endtask

    task automatic test_full_kick();
        int expFrame;
        kick_req = 1'b1;
        cycle();
        kick_req = 1'b0;
        checks++;
        if (kick_busy !== 1'b1 || frame_idx !== 3'd0) begin
            errors++;
            $display("[TB] FAIL kick_accept: got busy=%0b frame=%0d required busy=1 frame=0", kick_busy, frame_idx);
        end
        pulse_vsync();
        cycle();
        for (int p = 1; p <= 24; p++) begin
            pulse_vsync();
            expFrame = (p == 24) ? 0 : p / 4;
            checks++;
            if (frame_idx !== 3'(expFrame) || kick_done !== (p == 24) || kick_busy !== (p != 24)) begin
                errors++;
                $display("[TB] FAIL kick_step_%0d: got frame=%0d done=%0b busy=%0b required frame=%0d done=%0b busy=%0b",
                         p, frame_idx, kick_done, kick_busy, expFrame, p == 24, p != 24);
            end
            if (p == 20) begin
                draw_x = 10'd195; draw_y = 10'd311;
                cycle();
                checks++;
                if (rom_address !== 16'd64511 || sprite_on !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL frame5_corner: got addr=%0d on=%0b required addr=64511 on=1", rom_address, sprite_on);
                end
                draw_x = 10'd1023; draw_y = 10'd1023;
            end
            cycle();
            checks++;
            if (kick_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL done_width_%0d: got done=%0b required 0", p, kick_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        kick_req    = 1'b1;
        vsync_start = 1'b1;
        cycle();
        vsync_start = 1'b0;
        kick_req    = 1'b0;
        checks++;
        if (kick_busy !== 1'b1 || frame_idx !== 3'd0) begin
            errors++;
            $display("[TB] FAIL same_cycle_accept: got busy=%0b frame=%0d required busy=1 frame=0", kick_busy, frame_idx);
        end
        // If entry went through ARMED the fourth pulse would not yet advance the frame.
        for (int p = 1; p <= 24; p++) begin
            kick_req = (p >= 4 && p <= 9);
            pulse_vsync();
            if (p == 4 || p == 8 || p == 24) begin
                checks++;
                if (frame_idx !== 3'((p == 24) ? 0 : p / 4) || kick_done !== (p == 24)) begin
                    errors++;
                    $display("[TB] FAIL same_cycle_step_%0d: got frame=%0d done=%0b required frame=%0d done=%0b",
                             p, frame_idx, kick_done, (p == 24) ? 0 : p / 4, p == 24);
                end
            end
            kick_req = 1'b0;
            cycle();
        end
        repeat (3) cycle();
        checks++;
        if (kick_busy !== 1'b0 || kick_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL same_cycle_idle_after: got busy=%0b done=%0b required 0 0", kick_busy, kick_done);
        end
    endtask

    task automatic test_reset_mid();
        int doneSeen;
        kick_req = 1'b1;
        cycle();
        kick_req = 1'b0;
        pulse_vsync();
        for (int p = 1; p <= 12; p++) begin
            pulse_vsync();
            cycle();
        end
        checks++;
        if (frame_idx !== 3'd3) begin
            errors++;
            $display("[TB] FAIL mid_frame3: got frame=%0d required 3", frame_idx);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (frame_idx !== 3'd0 || kick_busy !== 1'b0 || kick_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_async: got frame=%0d busy=%0b done=%0b required 0 0 0", frame_idx, kick_busy, kick_done);
        end
        cycle();
        reset_n = 1'b1;
        doneSeen = 0;
        repeat (3) begin
            cycle();
            if (kick_done === 1'b1) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0 || kick_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_done: got done_pulses=%0d busy=%0b required 0 0", doneSeen, kick_busy);
        end
        kick_req = 1'b1;
        cycle();
        kick_req = 1'b0;
        pulse_vsync();
        doneSeen = 0;
        for (int p = 1; p <= 24; p++) begin
            pulse_vsync();
            if (kick_done === 1'b1) doneSeen++;
            if (p == 23 || p == 24) begin
                checks++;
                if (kick_done !== (p == 24) || kick_busy !== (p != 24)) begin
                    errors++;
                    $display("[TB] FAIL rerun_step_%0d: got done=%0b busy=%0b required done=%0b busy=%0b",
                             p, kick_done, kick_busy, p == 24, p != 24);
                end
            end
            cycle();
        end
        checks++;
        if (doneSeen !== 1) begin
            errors++;
            $display("[TB] FAIL rerun_done_count: got %0d required 1", doneSeen);
        end
    endtask

    // Scenario sequence; each task does its own comparisons.
    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        vsync_start = 1'b0;
        draw_x      = 10'd1023;
        draw_y      = 10'd1023;
        pos_x       = 10'd0;
        pos_y       = 10'd0;
        mirror      = 1'b0;
        kick_req    = 1'b0;
        test_reset();
        test_addr_corners();
        test_mirror();
        test_full_kick();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kyo_kick_sequencer.md
# kyo_kick_sequencer

Animation and address controller for the kick sprite path. It sequences the kick animation on a vertical-sync time base. Each cycle it converts the current VGA draw coordinate into a sprite ROM address plus a `sprite_on` flag, which feed the kick sprite renderer and the pixel mux. Frame index and sprite position update only at frame boundaries, so one screen never mixes two animation frames or two positions.

## Interface
- `FRAME_W`, 96: sprite frame width in pixels
- `FRAME_H`, 112: sprite frame height in pixels
- `NUM_FRAMES`, 6: frames in the kick animation. Frame 0 is also the idle pose.
- `HOLD_VS`, 4: vsync periods each frame is displayed
- `ADDR_W`, 16: ROM address width. Requires `NUM_FRAMES*FRAME_W*FRAME_H <= 2**ADDR_W`.

Ports:
- `vga_clk` in, 1: pixel clock; all logic on posedge
- `reset_n` in, 1: asynchronous, active-low reset
- `vsync_start` in, 1: single-cycle pulse at the start of vertical blank
- `draw_x`, `draw_y` in, 10 each: current pixel coordinate
- `pos_x`, `pos_y` in, 10 each: sprite top-left corner on screen
- `mirror` in, 1: flip horizontally (character faces left)
- `kick_req` in, 1: request a kick; level or pulse
- `kick_busy` out, 1: high while state is not IDLE
- `kick_done` out, 1: single-cycle pulse when the animation completes
- `frame_idx` out, 3: currently displayed frame
- `rom_address` out, ADDR_W: address to the sprite ROM
- `sprite_on` out, 1: the addressed pixel lies inside the sprite box

## Operation
- States:
  - IDLE: shows frame 0.
  - ARMED: request accepted, waiting for a frame boundary.
  - ACTIVE: animating.
- Transitions:
  - IDLE with `kick_req` and no `vsync_start` goes to ARMED.
  - IDLE with `kick_req` and `vsync_start` in the same cycle goes directly to ACTIVE.
  - ARMED with `vsync_start` goes to ACTIVE.
  - Entering ACTIVE sets `frame_idx`=0 and `hold_cnt`=0.
- ACTIVE, on each `vsync_start`:
  - If `hold_cnt`≠HOLD_VS-1, then `hold_cnt`++.
  - Otherwise `hold_cnt`=0. If `frame_idx`=NUM_FRAMES-1, pulse `kick_done`, return to IDLE and set `frame_idx`=0. Otherwise `frame_idx`++.
- `kick_req` is ignored in ARMED and ACTIVE. Requests are not queued.
- Total duration from ACTIVE entry to `kick_done`: NUM_FRAMES*HOLD_VS `vsync_start` pulses (24 at defaults).
- Shadow registers `pos_x_s`, `pos_y_s`, `mirror_s` load from the inputs on every `vsync_start`. All address math uses only the shadows.
- Address generation, in 10-bit unsigned arithmetic:
  - `dx` = `draw_x`−`pos_x_s` and `dy` = `draw_y`−`pos_y_s`, with wrap.
  - Inside the box when `dx`<FRAME_W and `dy`<FRAME_H. Negative offsets wrap to large values and fall outside.
  - `col` = `mirror_s` ? FRAME_W−1−`dx` : `dx`.
  - `rom_address` = `frame_base(frame_idx)` + `dy`*FRAME_W + `col`, truncated to ADDR_W.
  - `frame_base(f)` = f*FRAME_W*FRAME_H, taken from a constant table with no runtime multiply by frame. `dy`*FRAME_W is a constant multiply (shift-add).
- Outside the box: `rom_address`=0 and `sprite_on`=0.
- `frame_idx` used for addressing is the registered value. A change on `vsync_start` takes effect on the next cycle, which is inside blanking.

## Timing
- Reset values:
  - state IDLE, `hold_cnt`=0, `frame_idx`=0
  - shadows 0
  - `rom_address`=0, `sprite_on`=0, `kick_busy`=0, `kick_done`=0
- Address latency: `rom_address` and `sprite_on` are registered, valid 1 `vga_clk` cycle after the `draw_x`/`draw_y` they correspond to.
  - The ROM samples on negedge and the renderer registers RGB on the following posedge.
  - The draw coordinate must therefore lead the displayed pixel by 2 cycles.
- `kick_busy` rises the cycle after `kick_req` is accepted. It falls in the same cycle as the `kick_done` pulse.
- `kick_done` is high for exactly one cycle, the cycle after the final `vsync_start`.
- Reset asserted mid-ACTIVE: immediate return to IDLE with frame 0. No `kick_done` is emitted.
- `vsync_start` held high for multiple cycles is illegal. The block counts one step per high cycle.

## Structure
- Package `kof_sprite_pkg` holds:
  - the `seq_state_t` enum (IDLE, ARMED, ACTIVE)
  - defaults for FRAME_W, FRAME_H, NUM_FRAMES
  - the `frame_base` function
- Sub-module `kyo_kick_addr_gen` (shadow-position inputs, draw coordinate, `frame_idx` → registered `rom_address`, `sprite_on`).
- The FSM and counters stay in the top module.

## Test plan
- Reset check: assert `reset_n`=0 → every output 0, `frame_idx`=0; release, no stimulus → outputs stay 0 and `kick_busy`=0.
- Address corners (IDLE, pos (100,200), no mirror):
  - draw (100,200) → `rom_address` 0, `sprite_on` 1, one cycle later
  - draw (195,311) → 10751
  - draw (99,200) → `sprite_on` 0
  - draw (196,200) → `sprite_on` 0
- Mirror: `mirror`=1 latched at `vsync_start`, draw (100,200) → 95; draw (195,200) → 0.
- Full kick: pulse `kick_req`, then issue 24 `vsync_start` pulses.
  - `frame_idx` steps 0→5, changing every 4 pulses.
  - `kick_done` fires once after the 24th pulse; `kick_busy` drops with it.
  - In frame 5, draw (195,311) → 64511.
- Same-cycle request: `kick_req` together with `vsync_start` in IDLE → ACTIVE the next cycle. A `kick_req` during ACTIVE changes nothing.
- Reset mid-animation: assert `reset_n` at `frame_idx`=3 → IDLE, frame 0, no `kick_done`. A new request then runs the full 24-pulse sequence.
